// File: rtl/core_ctrl_pkg.sv
// Shared types and constants for the pipeline control block.
// The state encoding is 2 bits wide: boot, run, hold, redirect.
package core_ctrl_pkg;

    typedef enum logic [1:0] {
        CtrlStateBoot  = 2'd0,
        CtrlStateRun   = 2'd1,
        CtrlStateHold  = 2'd2,
        CtrlStateRedir = 2'd3
    } ctrl_state_e;

    localparam logic [31:0] CpuRstAddress = 32'h0000_0000;
    localparam logic [31:0] TrapAddress   = 32'h0000_0100;
    localparam logic        JumpEnable    = 1'b1;
    localparam logic        HoldNone      = 1'b0;

endpackage

// File: rtl/core_ctrl.sv
// Pipeline control: owns the PC, issues fetches, and drives flush/hold for IF/ID and ID/EX.
// Redirects that arrive while stalled are parked and applied once the stall clears.
module core_ctrl
    import core_ctrl_pkg::*;
#(
    parameter logic [31:0] RST_ADDR  = CpuRstAddress,
    parameter logic [31:0] TRAP_ADDR = TrapAddress
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_in,
    input  logic [31:0] jump_addr_in,
    input  logic        hold_flag_ex_in,
    input  logic        hold_flag_bus_in,
    input  logic        fetch_ready_in,
    output logic [31:0] pc_out,
    output logic        fetch_req_out,
    output logic        flush_if_id_out,
    output logic        flush_id_ex_out,
    output logic        hold_pipe_out,
    output logic        misalign_out
);

    function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
        return addr_lsbs != 2'b00;
    endfunction

    ctrl_state_e state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic        pend_valid_q, pend_valid_d;
    logic        misalign_q, misalign_d;

    logic        jump;
    logic        hold;
    logic        jump_trap;
    logic [31:0] jump_tgt;

    assign jump      = (jump_flag_in == JumpEnable);
    assign hold      = ((hold_flag_ex_in | hold_flag_bus_in) != HoldNone);
    assign jump_trap = is_misaligned(jump_addr_in[1:0]);
    assign jump_tgt  = jump_trap ? TRAP_ADDR : jump_addr_in;

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        pend_addr_d     = pend_addr_q;
        pend_valid_d    = pend_valid_q;
        misalign_d      = misalign_q;
        fetch_req_out   = 1'b0;
        flush_if_id_out = 1'b0;
        flush_id_ex_out = 1'b0;
        hold_pipe_out   = 1'b0;

        case (state_q)
            CtrlStateBoot: begin
                if (jump) begin
                    pc_d            = jump_tgt;
                    misalign_d      = misalign_q | jump_trap;
                    flush_if_id_out = 1'b1;
                    flush_id_ex_out = 1'b1;
                end
                state_d = CtrlStateRun;
            end
            CtrlStateRun: begin
                fetch_req_out = 1'b1;
                // Jump beats hold: the flush discards whatever was fetched this cycle.
                if (jump) begin
                    pc_d            = jump_tgt;
                    misalign_d      = misalign_q | jump_trap;
                    flush_if_id_out = 1'b1;
                    flush_id_ex_out = 1'b1;
                end else if (hold) begin
                    hold_pipe_out = 1'b1;
                    state_d       = CtrlStateHold;
                end else if (fetch_ready_in) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            CtrlStateHold: begin
                hold_pipe_out = 1'b1;
                if (jump && !pend_valid_q) begin
                    pend_valid_d    = 1'b1;
                    pend_addr_d     = jump_tgt;
                    misalign_d      = misalign_q | jump_trap;
                    flush_if_id_out = 1'b1;
                    flush_id_ex_out = 1'b1;
                end
                // Use the next-state flag so a jump captured as hold drops is not lost.
                if (!hold) begin
                    state_d = pend_valid_d ? CtrlStateRedir : CtrlStateRun;
                end
            end
            CtrlStateRedir: begin
                pc_d            = pend_addr_q;
                pend_valid_d    = 1'b0;
                flush_if_id_out = 1'b1;
                flush_id_ex_out = 1'b1;
                state_d         = CtrlStateRun;
            end
            default: begin
                state_d = CtrlStateBoot;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= CtrlStateBoot;
            pc_q         <= RST_ADDR;
            pend_addr_q  <= 32'h0;
            pend_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_addr_q  <= pend_addr_d;
            pend_valid_q <= pend_valid_d;
            misalign_q   <= misalign_d;
        end
    end

    assign pc_out       = pc_q;
    assign misalign_out = misalign_q;

endmodule

// File: tb/tb_core_ctrl.sv
// Directed, table-driven bench for core_ctrl: one row per clock cycle, outputs checked
// mid-cycle against hand-computed values, plus a reset-mid-hold and PC-wrap sequence.
module tb_core_ctrl;

    logic        clk;
    logic        rst;
    logic        jump_flag_in;
    logic [31:0] jump_addr_in;
    logic        hold_flag_ex_in;
    logic        hold_flag_bus_in;
    logic        fetch_ready_in;
    logic [31:0] pc_out;
    logic        fetch_req_out;
    logic        flush_if_id_out;
    logic        flush_id_ex_out;
    logic        hold_pipe_out;
    logic        misalign_out;

    int checks = 0;
    int errors = 0;

    core_ctrl #(
        .RST_ADDR (32'h0000_0000),
        .TRAP_ADDR(32'h0000_0100)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .jump_flag_in    (jump_flag_in),
        .jump_addr_in    (jump_addr_in),
        .hold_flag_ex_in (hold_flag_ex_in),
        .hold_flag_bus_in(hold_flag_bus_in),
        .fetch_ready_in  (fetch_ready_in),
        .pc_out          (pc_out),
        .fetch_req_out   (fetch_req_out),
        .flush_if_id_out (flush_if_id_out),
        .flush_id_ex_out (flush_id_ex_out),
        .hold_pipe_out   (hold_pipe_out),
        .misalign_out    (misalign_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        jump;
        logic [31:0] addr;
        logic        hex;
        logic        hbus;
        logic        rdy;
        logic [31:0] pc;
        logic        req;
        logic        fif;
        logic        fid;
        logic        hp;
        logic        mis;
    } vec_t;

    localparam int NumVecs = 24;
    vec_t vecs[NumVecs];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [31:0] pc, input logic req,
                              input logic fif, input logic fid, input logic hp,
                              input logic mis);
        check({tag, ".pc"}, pc_out, pc);
        check({tag, ".req"}, {31'b0, fetch_req_out}, {31'b0, req});
        check({tag, ".flush_if_id"}, {31'b0, flush_if_id_out}, {31'b0, fif});
        check({tag, ".flush_id_ex"}, {31'b0, flush_id_ex_out}, {31'b0, fid});
        check({tag, ".hold_pipe"}, {31'b0, hold_pipe_out}, {31'b0, hp});
        check({tag, ".misalign"}, {31'b0, misalign_out}, {31'b0, mis});
    endtask

    task automatic drive(input logic j, input logic [31:0] a, input logic hex,
                         input logic hbus, input logic rdy);
        jump_flag_in     = j;
        jump_addr_in     = a;
        hold_flag_ex_in  = hex;
        hold_flag_bus_in = hbus;
        fetch_ready_in   = rdy;
    endtask

    initial begin
        //          j     addr          hex   hbus  rdy   | pc            req   fif   fid   hp    mis
        vecs[0]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0008, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_000c, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 32'h200,      1'b0, 1'b0, 1'b1, 32'h0000_0014, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 32'h202,      1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        // Bus hold for four cycles; first jump captured, second ignored.
        vecs[13] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{1'b1, 32'h300,      1'b0, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[15] = '{1'b1, 32'h400,      1'b0, 1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[16] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[17] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[18] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[19] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0300, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[20] = '{1'b1, 32'h40,       1'b0, 1'b0, 1'b1, 32'h0000_0304, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        // Jump and hold together: jump wins, hold is acted on next cycle.
        vecs[21] = '{1'b1, 32'h80,       1'b1, 1'b0, 1'b1, 32'h0000_0040, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[22] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0000_0080, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[23] = '{1'b1, 32'h500,      1'b1, 1'b0, 1'b1, 32'h0000_0080, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        check_outs("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NumVecs; i++) begin
            drive(vecs[i].jump, vecs[i].addr, vecs[i].hex, vecs[i].hbus, vecs[i].rdy);
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].pc, vecs[i].req, vecs[i].fif,
                       vecs[i].fid, vecs[i].hp, vecs[i].mis);
            @(negedge clk);
        end

        // Async reset in the middle of a hold with a redirect pending.
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check_outs("rst_mid_hold", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        check_outs("post_rst_boot", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check_outs("post_rst_run", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check_outs("pend_lost", 32'h4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // PC wraps modulo 2^32.
        drive(1'b1, 32'hffff_fffc, 1'b0, 1'b0, 1'b1);
        #1;
        check_outs("jump_top", 32'h4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        #1;
        check_outs("at_top", 32'hffff_fffc, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check_outs("wrap", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_ctrl.md
# core_ctrl

Pipeline control block sitting directly downstream of the execute stage. It consumes the execute stage's `hold_flag`/`jump_flag`/`jump_addr` and the instruction-bus handshake. It owns the program counter and issues fetch requests. It generates the flush and hold controls for the IF/ID and ID/EX pipeline registers, and it traps misaligned jump targets.

## Interface
Parameters:
- `RST_ADDR`, default 32'h0000_0000 (`CPURstAddress`): PC value after reset.
- `TRAP_ADDR`, default 32'h0000_0100: PC target on a misaligned jump.

Ports:
- `clk`  in  1  core clock. One clock domain.
- `rst`  in  1  asynchronous reset, active-low.
- `jump_flag_in`  in  1  execute stage requests a redirect.
- `jump_addr_in`  in  32  redirect target.
- `hold_flag_ex_in`  in  1  execute stage stall request.
- `hold_flag_bus_in`  in  1  data/peripheral bus busy.
- `fetch_ready_in`  in  1  instruction memory accepts the request this cycle. Data is returned into IF/ID at the same edge.
- `pc_out`  out  32  fetch address.
- `fetch_req_out`  out  1  fetch request valid.
- `flush_if_id_out`  out  1  IF/ID loads a NOP at the next edge.
- `flush_id_ex_out`  out  1  ID/EX loads a NOP at the next edge.
- `hold_pipe_out`  out  1  IF/ID and ID/EX keep their contents.
- `misalign_out`  out  1  sticky misaligned-jump flag.

## Operation
- States:
  - S_BOOT: one cycle after reset release.
  - S_RUN: normal fetching.
  - S_HOLD: stalled.
  - S_REDIR: apply a pending redirect.
- Jump acceptance in S_RUN and S_BOOT:
  - A jump is accepted when `jump_flag_in`=1.
  - `pc` <= `jump_addr_in`, or `TRAP_ADDR` if `jump_addr_in[1:0]`!=0. A trap also sets `misalign_out`.
  - `flush_if_id_out` and `flush_id_ex_out` are 1 in the same cycle.
  - Any fetch handshake completing that cycle is discarded by the flush.
- S_BOOT: `fetch_req_out`=0. Go to S_RUN.
- S_RUN:
  - `fetch_req_out`=1.
  - If `fetch_req_out && fetch_ready_in` and there is no jump: `pc` <= `pc`+4 (wraps modulo 2^32).
  - If hold (`hold_flag_ex_in | hold_flag_bus_in`) and no jump: go to S_HOLD. `pc` does not advance that cycle, even if `fetch_ready_in`=1.
- Priority: jump > hold > sequential advance.
- S_HOLD:
  - `fetch_req_out`=0, `hold_pipe_out`=1, `pc` frozen.
  - A jump seen in S_HOLD captures the target (post-alignment check) into `pend_addr` and sets `pend_valid`. The first jump wins and later ones are ignored until the pending redirect is consumed. Flushes are asserted on the capture cycle only.
  - When hold drops: go to S_REDIR if `pend_valid`, else S_RUN.
- S_REDIR:
  - `pc` <= `pend_addr`, `pend_valid` <= 0, `fetch_req_out`=0, flush both pipeline registers.
  - Go to S_RUN.
- `misalign_out` clears only on reset.

## Timing
- Reset (`rst`=0, async) values:
  - state = S_BOOT, `pc_out` = `RST_ADDR`, `pend_valid` = 0, `pend_addr` = 0.
  - All flush and hold outputs are 0. `fetch_req_out` = 0, `misalign_out` = 0.
- Reset asserted mid-hold or with a redirect pending discards everything.
- `pc_out`, `misalign_out` and the state are registered. Flush, hold and `fetch_req_out` are combinational from the state and current inputs. This gives zero-cycle flush on a jump.
- Redirect latency:
  - From S_RUN: the target appears on `pc_out` one cycle after `jump_flag_in`.
  - From S_HOLD: the target appears two cycles after hold deasserts (S_REDIR, then visible in S_RUN).
- `hold_pipe_out`=1 throughout every S_HOLD cycle, and also in the S_RUN cycle that detects hold, combinationally.
- Jump and hold in the same S_RUN cycle: the jump is taken and the state stays S_RUN. A hold persisting into the next cycle enters S_HOLD then.

## Structure
- Add to `defines.v`:
  - State encodings `CtrlState_BOOT/RUN/HOLD/REDIR` (2 bits).
  - `TrapAddress`.
  - Reuse the existing `JumpEnable`/`HoldNone`/`CPURstAddress`.
- No sub-modules. The misaligned-target check is a local function; a separate module is not justified.

## Test plan
- Reset release with `fetch_ready_in`=1 → `pc_out` 0x0 (BOOT, `fetch_req_out`=0), then 0x0 with `fetch_req_out`=1, then 0x4, 0x8 on successive edges.
- `fetch_ready_in` low for 3 cycles at `pc`=0x10 → `pc` stays 0x10 and `fetch_req_out` stays 1; advances to 0x14 on the first ready cycle.
- Jump to 0x200 in S_RUN with `fetch_ready_in`=1 → both flushes high that cycle; next `pc_out`=0x200, not 0x204.
- Jump to 0x202 → `pc_out`=0x100 next cycle, `misalign_out`=1 and staying 1 until `rst`=0.
- Bus hold for 4 cycles with a jump to 0x300 in the 2nd and a jump to 0x400 in the 3rd → `pc` frozen; after hold drops: S_REDIR (flush), then `pc_out`=0x300.
- Jump and hold together at `pc`=0x40 → `pc` becomes the jump target; then S_HOLD with `pc` frozen. Async `rst` pulse mid-hold → `pc_out`=`RST_ADDR` immediately and the pending redirect is lost.
